// File: rtl/fedp_feeder.sv
// fedp_feeder: job sequencer in front of the 4-lane, 2-stage INT8 dot-product
// unit (FEDP). It takes one job (initial sum + chunk count), streams 4-wide
// weight/activation chunks into the FEDP and closes the accumulation loop by
// feeding FEDP's result back into its partial_sum input. The final 16-bit sum
// is returned on a valid/ready output.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   job_valid/job_ready job request handshake (ready only in IDLE)
//   job_chunks, job_init chunk count (0 legal) and signed initial sum
//   op_valid/op_ready   operand beat handshake (ready only in RUN)
//   op_w, op_a          four packed signed int8 lanes, lane i = [8i+7:8i]
//   fedp_w0..3, fedp_a0..3  registered operands to the FEDP
//   fedp_psum           partial_sum to the FEDP (combinational)
//   fedp_result         FEDP result
//   out_valid/out_ready final sum handshake
//   out_sum             signed final sum (registered)
//   bubble_cnt          only with FEDP_FEED_PERF_EN: saturating count of
//                       RUN cycles without an operand beat
//
// Optional feature macro: FEDP_FEED_PERF_EN.
module fedp_feeder #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             job_valid,
  output logic             job_ready,
  input  logic [CNT_W-1:0] job_chunks,
  input  logic [15:0]      job_init,
  input  logic             op_valid,
  output logic             op_ready,
  input  logic [31:0]      op_w,
  input  logic [31:0]      op_a,
  output logic [7:0]       fedp_w0,
  output logic [7:0]       fedp_w1,
  output logic [7:0]       fedp_w2,
  output logic [7:0]       fedp_w3,
  output logic [7:0]       fedp_a0,
  output logic [7:0]       fedp_a1,
  output logic [7:0]       fedp_a2,
  output logic [7:0]       fedp_a3,
  output logic [15:0]      fedp_psum,
  input  logic [15:0]      fedp_result,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [15:0]      out_sum
`ifdef FEDP_FEED_PERF_EN
  ,
  output logic [15:0]      bubble_cnt
`endif
);

  typedef enum logic [2:0] {IDLE, PRIME, RUN, DRAIN, DONE} state_t;

  state_t                  state, state_nxt;
  logic [CNT_W-1:0]        rem;
  logic signed [15:0]      init_q;
  logic [1:0]              drain_cnt;
  logic signed [7:0]       w_p0 [4];
  logic signed [7:0]       a_p0 [4];
  logic signed [15:0]      sum_p1;
  logic                    beat;
  logic                    job_take;

  assign beat     = op_valid && (state == RUN);
  assign job_take = job_valid && (state == IDLE);

  always_comb begin
    state_nxt = state;
    job_ready = 1'b0;
    op_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        job_ready = 1'b1;
        if (job_valid) state_nxt = PRIME;
      end
      PRIME: state_nxt = (rem != '0) ? RUN : DRAIN;
      RUN: begin
        op_ready = 1'b1;
        if (op_valid && rem == CNT_W'(1)) state_nxt = DRAIN;
      end
      // Three cycles let the last chunk cross both FEDP stages.
      DRAIN: if (drain_cnt == 2'd2) state_nxt = DONE;
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      rem       <= '0;
      init_q    <= '0;
      drain_cnt <= '0;
      sum_p1    <= '0;
      for (int i = 0; i < 4; i++) begin
        w_p0[i] <= '0;
        a_p0[i] <= '0;
      end
    end else begin
      state <= state_nxt;
      if (job_take) begin
        rem    <= job_chunks;
        init_q <= job_init;
      end else if (beat) begin
        rem <= rem - 1'b1;
      end
      drain_cnt <= (state == DRAIN) ? drain_cnt + 2'd1 : 2'd0;
      // Stage p0: operand registers; zero when no beat so the loop holds.
      for (int i = 0; i < 4; i++) begin
        w_p0[i] <= beat ? op_w[8*i +: 8] : 8'd0;
        a_p0[i] <= beat ? op_a[8*i +: 8] : 8'd0;
      end
      // Stage p1: capture the settled accumulation at the end of DRAIN.
      if (state == DRAIN && drain_cnt == 2'd2) sum_p1 <= fedp_result;
    end
  end

`ifdef FEDP_FEED_PERF_EN
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  always_ff @(posedge clk) begin
    if (rst || job_take) bubble_cnt <= '0;
    else if (state == RUN && !op_valid) bubble_cnt <= sat_inc(bubble_cnt);
  end
`endif

  // PRIME seeds the loop with the initial sum; afterwards the result recirculates.
  assign fedp_psum = (state == PRIME) ? init_q : fedp_result;

  assign fedp_w0 = w_p0[0];
  assign fedp_w1 = w_p0[1];
  assign fedp_w2 = w_p0[2];
  assign fedp_w3 = w_p0[3];
  assign fedp_a0 = a_p0[0];
  assign fedp_a1 = a_p0[1];
  assign fedp_a2 = a_p0[2];
  assign fedp_a3 = a_p0[3];
  assign out_sum = sum_p1;

endmodule

// File: tb/tb_fedp_feeder.sv
// Scoreboard bench for fedp_feeder, including a behavioural 2-stage FEDP.
module tb_fedp_feeder;
  logic        clk;
  logic        rst;
  logic        job_valid;
  logic        job_ready;
  logic [7:0]  job_chunks;
  logic [15:0] job_init;
  logic        op_valid;
  logic        op_ready;
  logic [31:0] op_w;
  logic [31:0] op_a;
  logic [7:0]  fedp_w0, fedp_w1, fedp_w2, fedp_w3;
  logic [7:0]  fedp_a0, fedp_a1, fedp_a2, fedp_a3;
  logic [15:0] fedp_psum;
  logic [15:0] fedp_result;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_sum;
`ifdef FEDP_FEED_PERF_EN
  logic [15:0] bubble_cnt;
`endif

  fedp_feeder #(.CNT_W(8)) dut (
    .clk(clk), .rst(rst),
    .job_valid(job_valid), .job_ready(job_ready),
    .job_chunks(job_chunks), .job_init(job_init),
    .op_valid(op_valid), .op_ready(op_ready), .op_w(op_w), .op_a(op_a),
    .fedp_w0(fedp_w0), .fedp_w1(fedp_w1), .fedp_w2(fedp_w2), .fedp_w3(fedp_w3),
    .fedp_a0(fedp_a0), .fedp_a1(fedp_a1), .fedp_a2(fedp_a2), .fedp_a3(fedp_a3),
    .fedp_psum(fedp_psum), .fedp_result(fedp_result),
    .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum)
`ifdef FEDP_FEED_PERF_EN
    , .bubble_cnt(bubble_cnt)
`endif
  );

  typedef struct {
    logic [15:0] sum;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   last_acc;
  int   job_acc;
  logic prev_valid = 1'b0;
  logic op_ready_seen = 1'b0;
  logic signed [15:0] prod_q;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int dot4(input logic [31:0] w, input logic [31:0] a);
    int s;
    s = 0;
    for (int i = 0; i < 4; i++) s += int'($signed(w[8*i +: 8])) * int'($signed(a[8*i +: 8]));
    return s;
  endfunction

  function automatic logic [31:0] pack4(input int l0, input int l1, input int l2, input int l3);
    logic [7:0] b0, b1, b2, b3;
    b0 = 8'(l0); b1 = 8'(l1); b2 = 8'(l2); b3 = 8'(l3);
    return {b3, b2, b1, b0};
  endfunction

  // FEDP: operands sampled at T, partial_sum at T+1, result visible at T+2.
  always @(posedge clk) begin
    if (rst) begin
      prod_q      <= '0;
      fedp_result <= '0;
    end else begin
      prod_q      <= 16'(dot4({fedp_w3, fedp_w2, fedp_w1, fedp_w0},
                              {fedp_a3, fedp_a2, fedp_a1, fedp_a0}));
      fedp_result <= prod_q + fedp_psum;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (op_ready) op_ready_seen = 1'b1;
    if (!rst && out_valid && !prev_valid) begin
      if (sb.size() == 0) begin
        check("sb_empty", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("out_sum", {16'd0, out_sum}, {16'd0, e.sum});
        check("out_latency", cyc, e.cyc);
      end
    end
    prev_valid = out_valid;
  end

  // All stimulus tasks start and end just after a rising edge.
  task automatic send_job(input logic [15:0] init, input int n);
    int k;
    job_valid  = 1'b1;
    job_init   = init;
    job_chunks = 8'(n);
    k = 0;
    @(negedge clk);
    while (!job_ready && k < 50) begin k++; @(negedge clk); end
    if (!job_ready) check("job_timeout", 0, 1);
    job_acc = cyc;
    @(posedge clk); #1;
    job_valid = 1'b0;
  endtask

  task automatic send_beat(input logic [31:0] w, input logic [31:0] a);
    int k;
    op_valid = 1'b1;
    op_w = w;
    op_a = a;
    k = 0;
    @(negedge clk);
    while (!op_ready && k < 50) begin k++; @(negedge clk); end
    if (!op_ready) check("beat_timeout", 0, 1);
    last_acc = cyc;
    @(posedge clk); #1;
    op_valid = 1'b0;
    op_w = '0;
    op_a = '0;
  endtask

  task automatic run_job(input logic [15:0] init, input int n,
                         input logic [31:0] w[4], input logic [31:0] a[4], input int gap);
    int   acc;
    exp_t e;
    acc = int'($signed(init));
    send_job(init, n);
    for (int k = 0; k < n; k++) begin
      acc += dot4(w[k], a[k]);
      send_beat(w[k], a[k]);
      if (gap > 0 && k < n - 1) begin
        repeat (gap) @(posedge clk);
        #1;
      end
    end
    e.sum = 16'(acc);
    e.cyc = (n == 0) ? job_acc + 5 : last_acc + 4;
    sb.push_back(e);
  endtask

  task automatic wait_valid();
    int k;
    k = 0;
    @(negedge clk);
    while (!out_valid && k < 50) begin k++; @(negedge clk); end
    if (!out_valid) check("valid_timeout", 0, 1);
  endtask

  task automatic finish_job();
    wait_valid();
    @(posedge clk); #1;
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_job_ready"}, job_ready, 1);
    check({tag, "_op_ready"}, op_ready, 0);
    check({tag, "_out_valid"}, out_valid, 0);
    check({tag, "_out_sum"}, out_sum, 0);
    check({tag, "_w"}, {fedp_w3, fedp_w2, fedp_w1, fedp_w0}, 0);
    check({tag, "_a"}, {fedp_a3, fedp_a2, fedp_a1, fedp_a0}, 0);
    check({tag, "_psum"}, fedp_psum, 0);
  endtask

  initial begin
    logic [31:0] w[4];
    logic [31:0] a[4];
    rst = 1'b1;
    job_valid = 1'b0; job_chunks = '0; job_init = '0;
    op_valid = 1'b0; op_w = '0; op_a = '0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_idle("reset");
    @(posedge clk); #1;
    rst = 1'b0;

    // Two chunks back-to-back: 100 + 10 - 8 = 102.
    w[0] = pack4(1, 2, 3, 4);     a[0] = pack4(1, 1, 1, 1);
    w[1] = pack4(-1, -1, -1, -1); a[1] = pack4(2, 2, 2, 2);
    w[2] = '0; a[2] = '0; w[3] = '0; a[3] = '0;
    run_job(16'd100, 2, w, a, 0);
    finish_job();

    // Same job with three bubbles between the beats.
    run_job(16'd100, 2, w, a, 3);
    finish_job();
`ifdef FEDP_FEED_PERF_EN
    check("bubble_cnt", bubble_cnt, 3);
`endif

    // Wrap: 32767 + 1 -> -32768.
    w[0] = pack4(1, 0, 0, 0); a[0] = pack4(1, 0, 0, 0);
    run_job(16'd32767, 1, w, a, 0);
    finish_job();
    check("wrap_sum", out_sum, 16'h8000);

    // Empty job returns job_init and never opens the operand port.
    op_ready_seen = 1'b0;
    run_job(16'hFFFB, 0, w, a, 0);
    finish_job();
    check("empty_sum", out_sum, 16'hFFFB);
    check("empty_op_ready", op_ready_seen, 0);

    // Backpressure: 50 + 3*(-4) = 38 held for 10 cycles.
    out_ready = 1'b0;
    w[0] = pack4(3, 0, 0, 0); a[0] = pack4(-4, 0, 0, 0);
    run_job(16'd50, 1, w, a, 0);
    wait_valid();
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      op_valid = i[0];
      op_w = 32'hFFFF_FFFF;
      op_a = 32'h0101_0101;
      @(negedge clk);
      check("bp_valid", out_valid, 1);
      check("bp_sum", out_sum, 16'd38);
      check("bp_job_ready", job_ready, 0);
      check("bp_op_ready", op_ready, 0);
      check("bp_w", {fedp_w3, fedp_w2, fedp_w1, fedp_w0}, 0);
    end
    @(posedge clk); #1;
    op_valid = 1'b0; op_w = '0; op_a = '0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check("bp_release_valid", out_valid, 0);
    check("bp_release_job_ready", job_ready, 1);
    @(posedge clk); #1;

    // Reset after 2 of 4 beats, then a fresh job: 7 + 4 = 11.
    w[0] = pack4(5, 5, 5, 5); a[0] = pack4(1, 1, 1, 1);
    send_job(16'd300, 4);
    send_beat(w[0], a[0]);
    send_beat(w[0], a[0]);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_idle("midrst");
    @(posedge clk); #1;
    rst = 1'b0;
    w[0] = pack4(2, 0, 0, 0); a[0] = pack4(2, 0, 0, 0);
    run_job(16'd7, 1, w, a, 0);
    finish_job();
    check("midrst_fresh_sum", out_sum, 16'd11);

    repeat (3) @(posedge clk);
    check("sb_left", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
